// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control sequencer: state encoding,
// opcode constants, datapath select encodings and the control-word struct.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_BOOT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_FAULT    = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles within one state and flags a
// timeout once the count reaches STALL_LIMIT with the access still pending.
module mem_wait_timer #(
    parameter int STALL_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ready,
    input  logic state_chg,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state_chg)
            cnt <= '0;
        else if (mem_req && !mem_ready)
            cnt <= cnt + 8'd1;
    end

    // A ready strobe in the limit cycle completes the access instead.
    assign timeout = mem_req && !mem_ready && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RISC-V control FSM: registered state, control strobes decoded
// combinationally from state (plus zero/mem_ready), sticky fault on timeout.
module multicycle_sequencer
    import ctrl_pkg::*;
#(
    parameter int STALL_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       RegWrite,
    output logic [3:0] state_o,
    output logic       fault
);

    state_e state, state_n;
    ctrl_t  ctrl;
    logic   timeout;
    logic   state_chg;

    assign state_chg = (state_n != state);

    mem_wait_timer #(.STALL_LIMIT(STALL_LIMIT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (ctrl.mem_req),
        .mem_ready (mem_ready),
        .state_chg (state_chg),
        .timeout   (timeout)
    );

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = zero;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            S_JALR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
                ctrl.pc_write   = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_BOOT:   state_n = S_FETCH;
            S_FETCH:  if (mem_ready) state_n = S_DECODE;
                      else if (timeout) state_n = S_FAULT;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_RTYPE:          state_n = S_EXECR;
                    OP_ITYPE:          state_n = S_EXECI;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
                    default:           state_n = S_FAULT;
                endcase
            end
            S_MEMADR:   state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
                        else if (timeout) state_n = S_FAULT;
            S_MEMWB:    state_n = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
                        else if (timeout) state_n = S_FAULT;
            S_EXECR, S_EXECI, S_JAL, S_JALR: state_n = S_ALUWB;
            S_ALUWB, S_BRANCH:               state_n = S_FETCH;
            default:    state_n = S_FAULT;
        endcase
    end

    // fault rises together with entry into FAULT and only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n == S_FAULT)
                fault <= 1'b1;
        end
    end

    assign state_o   = state;
    assign mem_req   = ctrl.mem_req;
    assign MemWrite  = ctrl.mem_write;
    assign IRWrite   = ctrl.ir_write;
    assign PCWrite   = ctrl.pc_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign ResultSrc = ctrl.result_src;
    assign RegWrite  = ctrl.reg_write;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: instruction-level model expands each instruction into its
// expected per-cycle states/strobes; a negedge monitor pops and compares.
module tb_multicycle_sequencer;

    localparam int LIM = 4;

    localparam int ST_BOOT = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                   ST_MEMREAD = 4, ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXECR = 7,
                   ST_EXECI = 8, ST_ALUWB = 9, ST_BRANCH = 10, ST_JAL = 11,
                   ST_JALR = 12, ST_FAULT = 15;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BEQ = 7'b1100011, JL = 7'b1101111,
                           JLR = 7'b1100111, BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, fault;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [3:0] state_o;

    typedef struct {
        logic [3:0]  st;
        logic [13:0] o;
        logic        f;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    multicycle_sequencer #(.STALL_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
        .RegWrite(RegWrite), .state_o(state_o), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] outs();
        return {mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ALUOp, ResultSrc, RegWrite};
    endfunction

    // Control-word table in the bit order of outs().
    function automatic logic [13:0] exp_out(int st, logic z, logic r);
        logic req = 0, mw = 0, irw = 0, pcw = 0, adr = 0, rw = 0;
        logic [1:0] a = 0, b = 0, alu = 0, res = 0;
        case (st)
            ST_FETCH:    begin req = 1; irw = r; pcw = r; b = 2; res = 2; end
            ST_DECODE:   begin a = 1; b = 1; end
            ST_MEMADR:   begin a = 2; b = 1; end
            ST_MEMREAD:  begin req = 1; adr = 1; end
            ST_MEMWB:    begin res = 1; rw = 1; end
            ST_MEMWRITE: begin req = 1; adr = 1; mw = 1; end
            ST_EXECR:    begin a = 2; alu = 2; end
            ST_EXECI:    begin a = 2; b = 1; alu = 2; end
            ST_ALUWB:    begin rw = 1; end
            ST_BRANCH:   begin a = 2; alu = 1; pcw = z; end
            ST_JAL:      begin a = 1; b = 2; pcw = 1; end
            ST_JALR:     begin a = 2; b = 1; res = 2; pcw = 1; end
            default: ;
        endcase
        return {req, mw, irw, pcw, adr, a, b, alu, res, rw};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("state", 32'(state_o), 32'(e.st));
            chk("ctrl", 32'(outs()), 32'(e.o));
            chk("fault", 32'(fault), 32'(e.f));
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle in state st with the given strobe inputs.
    task automatic cyc(input int st, input logic r, input logic z);
        exp_t e;
        mem_ready = r;
        zero = z;
        e.st = 4'(st);
        e.o = exp_out(st, z, r);
        e.f = (st == ST_FAULT);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Memory-wait state: stall cycles then ready, or timeout after LIM+1 stalls.
    task automatic mem_phase(input int st, input int stall, output bit faulted);
        faulted = (stall > LIM);
        for (int i = 0; i < (faulted ? LIM + 1 : stall); i++) cyc(st, 1'b0, rbit());
        if (!faulted) cyc(st, 1'b1, rbit());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'(ST_BOOT));
        chk("rst_fault", 32'(fault), 0);
        chk("rst_ctrl", 32'(outs()), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(ST_BOOT, rbit(), rbit());
    endtask

    task automatic fault_tail();
        for (int i = 0; i < 3; i++) begin
            op = 7'($urandom);
            cyc(ST_FAULT, rbit(), rbit());
        end
        do_reset();
    endtask

    task automatic run_instr(input logic [6:0] o, input int fs, input int ms, input logic z);
        bit f;
        op = 7'($urandom);
        mem_phase(ST_FETCH, fs, f);
        if (f) begin fault_tail(); return; end
        op = o;
        cyc(ST_DECODE, rbit(), rbit());
        f = 0;
        case (o)
            LW:  begin
                cyc(ST_MEMADR, rbit(), rbit());
                mem_phase(ST_MEMREAD, ms, f);
                if (!f) cyc(ST_MEMWB, rbit(), rbit());
            end
            SW:  begin
                cyc(ST_MEMADR, rbit(), rbit());
                mem_phase(ST_MEMWRITE, ms, f);
            end
            RT:  begin cyc(ST_EXECR, rbit(), rbit()); cyc(ST_ALUWB, rbit(), rbit()); end
            IT:  begin cyc(ST_EXECI, rbit(), rbit()); cyc(ST_ALUWB, rbit(), rbit()); end
            BEQ: cyc(ST_BRANCH, rbit(), z);
            JL:  begin cyc(ST_JAL, rbit(), rbit()); cyc(ST_ALUWB, rbit(), rbit()); end
            JLR: begin cyc(ST_JALR, rbit(), rbit()); cyc(ST_ALUWB, rbit(), rbit()); end
            default: f = 1;
        endcase
        if (f) fault_tail();
    endtask

    task automatic reset_mid_store();
        bit f;
        exp_t e;
        op = SW;
        mem_phase(ST_FETCH, 0, f);
        cyc(ST_DECODE, rbit(), rbit());
        cyc(ST_MEMADR, rbit(), rbit());
        cyc(ST_MEMWRITE, 1'b0, rbit());
        mem_ready = 1'b0;
        e.st = 4'(ST_MEMWRITE);
        e.o = exp_out(ST_MEMWRITE, zero, 1'b0);
        e.f = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        #2;
        chk("memwrite_pre_rst", 32'(MemWrite), 1);
        rst_n = 1'b0;
        #1;
        chk("memwrite_async", 32'(MemWrite), 0);
        chk("memreq_async", 32'(mem_req), 0);
        chk("regwrite_async", 32'(RegWrite), 0);
        chk("state_async", 32'(state_o), 32'(ST_BOOT));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(ST_BOOT, rbit(), rbit());
    endtask

    initial begin
        logic [6:0] legal [7];
        legal = '{LW, SW, RT, IT, BEQ, JL, JLR};
        rst_n = 1'b0;
        op = '0;
        zero = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("por_state", 32'(state_o), 32'(ST_BOOT));
        chk("por_fault", 32'(fault), 0);
        chk("por_ctrl", 32'(outs()), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(ST_BOOT, rbit(), rbit());

        run_instr(LW, 0, 0, 1'b0);
        run_instr(BEQ, 0, 0, 1'b1);
        run_instr(BEQ, 0, 0, 1'b0);
        run_instr(SW, 0, 3, 1'b0);
        run_instr(RT, LIM, 0, 1'b0);
        run_instr(LW, LIM, LIM, 1'b0);
        run_instr(IT, 0, 0, 1'b0);
        run_instr(JL, 1, 0, 1'b0);
        run_instr(JLR, 2, 0, 1'b0);
        run_instr(RT, LIM + 1, 0, 1'b0);
        run_instr(BAD, 0, 0, 1'b0);
        run_instr(LW, 0, LIM + 1, 1'b0);
        run_instr(SW, 1, LIM + 1, 1'b0);
        reset_mid_store();
        run_instr(JL, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [6:0] o;
            int fs, ms;
            o = ($urandom_range(0, 19) == 0) ? 7'($urandom) : legal[$urandom_range(0, 6)];
            fs = ($urandom_range(0, 19) == 0) ? LIM + 1 : int'($urandom_range(0, LIM));
            ms = ($urandom_range(0, 19) == 0) ? LIM + 1 : int'($urandom_range(0, LIM));
            run_instr(o, fs, ms, rbit());
        end

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
